arp_phase_gen: RTL and testbench
================================

ARP_PHASE_GEN -- requirements
Module: arp_phase_gen

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1024: clocks per sample tick (min 2).
REQ-002 SHALL have parameter NOTE_CYCLES, default 50000000: clocks per arpeggio note (min 2).
REQ-003 SHALL have parameter PHASE_W, default 16: phase accumulator width (min 12).
REQ-004 CLK100MHZ  input  1  sole clock, all state on rising edge.
REQ-005 CPU_RESETN  input  1  reset, asynchronous, active-low.
REQ-006 arp_toggle  input  1  one-cycle pulse from debouncer; flips arpeggiator enable.
REQ-007 sw  input  8  frequency offset from switches.
REQ-008 addra  output  8  sine table address to 256-entry BRAM.
REQ-009 sample_tick  output  1  one-cycle pulse per sample period.
REQ-010 note  output  2  current note index (LED display).
REQ-011 arp_on  output  1  arpeggiator enabled.

Function
REQ-012 Divider counts 0..SAMPLE_DIV-1 and wraps; sample_tick high exactly in cycles where counter == SAMPLE_DIV-1.
REQ-013 Base increment f_base = 746 + sw, 11-bit unsigned, range 746..1001.
REQ-014 Increment per note: 0 -> f_base; 1 -> f_base + (f_base>>2); 2 -> f_base + (f_base>>1); 3 -> f_base<<1; 11-bit, truncating shifts, no overflow possible (max 2002).
REQ-015 On the edge ending a sample_tick cycle, phase <= phase + inc(note), modulo 2^PHASE_W; no update otherwise.
REQ-016 addra = phase[PHASE_W-1:PHASE_W-8], driven from the phase register (changes on the same edge as phase).
REQ-017 sw/note changes take effect at the next sample tick; phase never reset by them (phase-continuous).
REQ-018 FSM states OFF and ARP; OFF: arp_on=0, note=0, note counter held at 0.
REQ-019 OFF + arp_toggle -> ARP, note=0, note counter cleared.
REQ-020 ARP: note counter counts 0..NOTE_CYCLES-1; on wrap, note advances per pattern (REQ-026).
REQ-021 ARP + arp_toggle -> OFF, note forced to 0, counter cleared, same edge.
REQ-022 arp_toggle coincident with note-counter wrap: toggle wins; no note advance.
REQ-023 arp_toggle held high multiple cycles: flips once per high cycle (debouncer guarantees single pulse).

Reset
REQ-024 CPU_RESETN low SHALL immediately clear divider, note counter, phase, addra, sample_tick, note, arp_on to 0 and FSM to OFF, regardless of clock.
REQ-025 After CPU_RESETN deasserts, first sample_tick in the SAMPLE_DIV-th clock cycle; reset mid-arpeggio returns to OFF with phase 0.

Configuration
REQ-026 Macro ARP_DESCEND_EN: defined -> up-down pattern 0,1,2,3,2,1,0,1,... (direction flag, cleared on reset/OFF entry); undefined -> ascending wrap 0,1,2,3,0,...; no direction register built when undefined.

Verification (SAMPLE_DIV=4, NOTE_CYCLES=16, PHASE_W=16)
REQ-027 Reset release, sw=0, arp off -> sample_tick every 4 cycles; after tick 1 phase=746, addra=2; after tick 4 phase=2984, addra=11.
REQ-028 sw=255, arp off -> phase advances 1001 per tick; after 66 ticks phase=66066 mod 65536=530, addra=2 (wrap checked).
REQ-029 sw=0, arp_toggle pulse -> arp_on=1, note 0,1,2,3,0 every 16 cycles; phase increments 746,932,1119,1492 respectively.
REQ-030 ARP_DESCEND_EN defined, arp on -> note sequence 0,1,2,3,2,1,0,1 at 16-cycle spacing.
REQ-031 arp_toggle on the note-wrap cycle -> arp_on=0, note=0, no advance; second toggle restarts at note 0.
REQ-032 CPU_RESETN pulled low asynchronously mid-note 2 -> all outputs 0 before next clock edge; arp_on=0 after release.

Source files
------------

// File: rtl/arp_phase_gen.sv
// Sample-rate phase accumulator with a 4-note arpeggiator that drives a 256-entry sine BRAM address.
// Build option: define ARP_DESCEND_EN for an up-down note pattern (default ascending wrap).
module arp_phase_gen #(
  parameter int SAMPLE_DIV  = 1024,
  parameter int NOTE_CYCLES = 50000000,
  parameter int PHASE_W     = 16
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       arp_toggle,
  input  logic [7:0] sw,
  output logic [7:0] addra,
  output logic       sample_tick,
  output logic [1:0] note,
  output logic       arp_on,
  output logic       dbg_state_o
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int NC_W  = (NOTE_CYCLES > 2) ? $clog2(NOTE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [NC_W-1:0]  NC_LAST  = NC_W'(NOTE_CYCLES - 1);

  typedef enum logic {S_OFF = 1'b0, S_ARP = 1'b1} state_t;

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick_q;
  logic [PHASE_W-1:0] phase_q;
  logic [10:0]        f_base;
  logic [10:0]        inc;
  state_t             state_q;
  logic [NC_W-1:0]    ncnt_q;
  logic [1:0]         note_q, next_note;
  logic               arp_on_q;

  // Sample divider; tick is registered so it is high exactly while div_q == DIV_LAST.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_d == DIV_LAST);
    end
  end

  // Note ratios approximate 1, 5/4, 3/2, 2 with truncating shifts; max 2002 fits 11 bits.
  always_comb begin
    f_base = 11'd746 + {3'b000, sw};
    inc    = f_base;
    case (note_q)
      2'd0: inc = f_base;
      2'd1: inc = f_base + {2'b00, f_base[10:2]};
      2'd2: inc = f_base + {1'b0, f_base[10:1]};
      2'd3: inc = {f_base[9:0], 1'b0};
      default: inc = f_base;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      phase_q <= '0;
    end else if (tick_q) begin
      phase_q <= phase_q + PHASE_W'(inc);
    end
  end

`ifdef ARP_DESCEND_EN
  logic dir_q, next_dir;

  // dir_q = 0 walks up toward note 3, 1 walks down toward note 0.
  always_comb begin
    next_dir  = dir_q;
    next_note = note_q + 2'd1;
    if (!dir_q) begin
      if (note_q == 2'd3) begin
        next_note = 2'd2;
        next_dir  = 1'b1;
      end
    end else begin
      if (note_q == 2'd0) begin
        next_note = 2'd1;
        next_dir  = 1'b0;
      end else begin
        next_note = note_q - 2'd1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      dir_q <= 1'b0;
    end else if (state_q == S_OFF || arp_toggle) begin
      dir_q <= 1'b0;
    end else if (ncnt_q == NC_LAST) begin
      dir_q <= next_dir;
    end
  end
`else
  always_comb begin
    next_note = note_q + 2'd1;
  end
`endif

  // Arpeggiator FSM; a toggle always wins over a coincident note-counter wrap.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q  <= S_OFF;
      ncnt_q   <= '0;
      note_q   <= 2'd0;
      arp_on_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          ncnt_q <= '0;
          note_q <= 2'd0;
          if (arp_toggle) begin
            state_q  <= S_ARP;
            arp_on_q <= 1'b1;
          end
        end
        S_ARP: begin
          if (arp_toggle) begin
            state_q  <= S_OFF;
            arp_on_q <= 1'b0;
            note_q   <= 2'd0;
            ncnt_q   <= '0;
          end else if (ncnt_q == NC_LAST) begin
            ncnt_q <= '0;
            note_q <= next_note;
          end else begin
            ncnt_q <= ncnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign addra       = phase_q[PHASE_W-1 -: 8];
  assign sample_tick = tick_q;
  assign note        = note_q;
  assign arp_on      = arp_on_q;
  assign dbg_state_o = (state_q == S_ARP);

endmodule

// File: tb/tb_arp_phase_gen.sv
// Randomized bench for arp_phase_gen against a cycle-count based reference model.
// Honours ARP_DESCEND_EN for the expected note pattern.
module tb_arp_phase_gen;

  localparam int SD = 4;
  localparam int NC = 16;
  localparam int PW = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tog = 1'b0;
  logic [7:0] sw = 8'd0;
  logic [7:0] addra;
  logic       sample_tick;
  logic [1:0] note;
  logic       arp_on;
  logic       dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  arp_phase_gen #(.SAMPLE_DIV(SD), .NOTE_CYCLES(NC), .PHASE_W(PW)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .arp_toggle (tog),
    .sw         (sw),
    .addra      (addra),
    .sample_tick(sample_tick),
    .note       (note),
    .arp_on     (arp_on),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: cycles since reset, cycles since arp enable, phase as an integer.
  int m_cyc, m_phase, m_arp_cyc;
  bit m_arp;
`ifdef ARP_DESCEND_EN
  localparam int PAT_LEN = 6;
  int pat[PAT_LEN] = '{0, 1, 2, 3, 2, 1};
  int exp_seq[5]   = '{0, 1, 2, 3, 2};
`else
  localparam int PAT_LEN = 4;
  int pat[PAT_LEN] = '{0, 1, 2, 3};
  int exp_seq[5]   = '{0, 1, 2, 3, 0};
`endif

  function automatic int m_note();
    return m_arp ? pat[(m_arp_cyc / NC) % PAT_LEN] : 0;
  endfunction

  function automatic int m_inc(input int n);
    int f;
    f = 746 + int'(sw);
    case (n)
      0: return f;
      1: return f + f / 4;
      2: return f + f / 2;
      default: return 2 * f;
    endcase
  endfunction

  function automatic bit m_tick();
    return (m_cyc % SD) == SD - 1;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_phase = 0; m_arp = 0; m_arp_cyc = 0;
  endtask

  // One clock: drive toggle, advance model with pre-edge values, return 1 time unit after the edge.
  task automatic step(input bit t);
    tog = t;
    @(posedge clk);
    if (m_tick()) m_phase = (m_phase + m_inc(m_note())) % (1 << PW);
    if (t) begin
      m_arp = !m_arp;
      m_arp_cyc = 0;
    end else if (m_arp) begin
      m_arp_cyc++;
    end
    m_cyc++;
    #1;
    tog = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (addra !== 8'd0) $display("FAIL reset_addra: got %0d expected 0", addra); else n_pass++;
    n_checks++; if (sample_tick !== 1'b0) $display("FAIL reset_tick: got %0b expected 0", sample_tick); else n_pass++;
    n_checks++; if (note !== 2'd0) $display("FAIL reset_note: got %0d expected 0", note); else n_pass++;
    n_checks++; if (arp_on !== 1'b0) $display("FAIL reset_arp_on: got %0b expected 0", arp_on); else n_pass++;
    n_checks++; if (dut.phase_q !== 16'd0) $display("FAIL reset_phase: got %0d expected 0", dut.phase_q); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sample_tick();
    sw = 8'd0;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b0);
      n_checks++;
      if (sample_tick !== m_tick()) $display("FAIL tick_cycle%0d: got %0b expected %0b", m_cyc, sample_tick, m_tick());
      else n_pass++;
      if (m_cyc == 4) begin
        n_checks++; if (dut.phase_q !== 16'd746) $display("FAIL tick1_phase: got %0d expected 746", dut.phase_q); else n_pass++;
        n_checks++; if (addra !== 8'd2) $display("FAIL tick1_addra: got %0d expected 2", addra); else n_pass++;
      end
    end
    n_checks++; if (dut.phase_q !== 16'd2984) $display("FAIL tick4_phase: got %0d expected 2984", dut.phase_q); else n_pass++;
    n_checks++; if (addra !== 8'd11) $display("FAIL tick4_addra: got %0d expected 11", addra); else n_pass++;
  endtask

  task automatic test_phase_wrap();
    sw = 8'd255;
    apply_reset();
    for (int i = 0; i < 66 * SD; i++) begin
      step(1'b0);
      n_checks++;
      if (dut.phase_q !== 16'(m_phase)) $display("FAIL wrap_phase c%0d: got %0d expected %0d", m_cyc, dut.phase_q, m_phase);
      else n_pass++;
    end
    n_checks++; if (dut.phase_q !== 16'd530) $display("FAIL wrap_final_phase: got %0d expected 530", dut.phase_q); else n_pass++;
    n_checks++; if (addra !== 8'd2) $display("FAIL wrap_final_addra: got %0d expected 2", addra); else n_pass++;
  endtask

  task automatic test_arp();
    int incs[4] = '{746, 932, 1119, 1492};
    int prev;
    sw = 8'd0;
    apply_reset();
    step(1'b1);
    n_checks++; if (arp_on !== 1'b1) $display("FAIL arp_enable: got %0b expected 1", arp_on); else n_pass++;
    for (int i = 0; i < 5 * NC; i++) begin
      if (m_arp_cyc % NC == 0) begin
        n_checks++;
        if (note !== 2'(exp_seq[m_arp_cyc / NC])) $display("FAIL arp_seq%0d: got %0d expected %0d", m_arp_cyc / NC, note, exp_seq[m_arp_cyc / NC]);
        else n_pass++;
      end
      prev = int'(dut.phase_q);
      if (m_tick() && m_arp_cyc % NC != NC - 1) begin
        step(1'b0);
        n_checks++;
        if (int'(dut.phase_q) !== (prev + incs[note]) % 65536) $display("FAIL arp_inc n%0d: got %0d expected %0d", note, (int'(dut.phase_q) - prev + 65536) % 65536, incs[note]);
        else n_pass++;
      end else begin
        step(1'b0);
      end
      n_checks++;
      if (note !== 2'(m_note()) || arp_on !== m_arp) $display("FAIL arp_note c%0d: got %0d/%0b expected %0d/%0b", m_arp_cyc, note, arp_on, m_note(), m_arp);
      else n_pass++;
    end
  endtask

  task automatic test_toggle_on_wrap();
    for (int i = 0; i < NC && (m_arp_cyc % NC) != NC - 1; i++) step(1'b0);
    step(1'b1);
    n_checks++; if (arp_on !== 1'b0) $display("FAIL twrap_arp_on: got %0b expected 0", arp_on); else n_pass++;
    n_checks++; if (note !== 2'd0) $display("FAIL twrap_note: got %0d expected 0", note); else n_pass++;
    for (int i = 0; i < 3; i++) step(1'b0);
    n_checks++; if (note !== 2'd0 || arp_on !== 1'b0) $display("FAIL twrap_off_hold: got %0d/%0b expected 0/0", note, arp_on); else n_pass++;
    step(1'b1);
    n_checks++; if (arp_on !== 1'b1 || note !== 2'd0) $display("FAIL twrap_restart: got %0d/%0b expected 0/1", note, arp_on); else n_pass++;
    for (int i = 0; i < NC - 1; i++) step(1'b0);
    n_checks++; if (note !== 2'd0) $display("FAIL twrap_before_adv: got %0d expected 0", note); else n_pass++;
    step(1'b0);
    n_checks++; if (note !== 2'd1) $display("FAIL twrap_first_adv: got %0d expected 1", note); else n_pass++;
  endtask

  task automatic test_random();
    sw = 8'($urandom);
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      step(bit'($urandom_range(0, 39) == 0));
      n_checks++;
      if (dut.phase_q !== 16'(m_phase) || addra !== 8'(m_phase >> 8))
        $display("FAIL rand_phase c%0d: got %0d/%0d expected %0d/%0d", m_cyc, dut.phase_q, addra, m_phase, m_phase >> 8);
      else n_pass++;
      n_checks++;
      if (note !== 2'(m_note()) || arp_on !== m_arp || sample_tick !== m_tick())
        $display("FAIL rand_ctl c%0d: got n%0d a%0b t%0b expected n%0d a%0b t%0b", m_cyc, note, arp_on, sample_tick, m_note(), m_arp, m_tick());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    sw = 8'($urandom);
    apply_reset();
    step(1'b1);
    for (int i = 0; i < 3 * NC && m_note() != 2; i++) step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b0);
    n_checks++; if (note !== 2'd2) $display("FAIL areset_pre_note: got %0d expected 2", note); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (addra !== 8'd0 || sample_tick !== 1'b0 || note !== 2'd0 || arp_on !== 1'b0 || dut.phase_q !== 16'd0)
      $display("FAIL areset_outputs: got a%0d t%0b n%0d on%0b p%0d expected all 0", addra, sample_tick, note, arp_on, dut.phase_q);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    n_checks++; if (arp_on !== 1'b0 || note !== 2'd0) $display("FAIL areset_release: got %0d/%0b expected 0/0", note, arp_on); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sample_tick();
    test_phase_wrap();
    test_arp();
    test_toggle_on_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
